// File: rtl/cb_seg_ctrl_param.sv
// cb_seg_ctrl_param - parametrised code-block segmentation controller.
// Pops one transport-block descriptor, then streams C- blocks of K- bits
// followed by C+ blocks of K+ bits, one bit per accepted transfer. Each bit
// is sourced from filler, the data FIFO or the external CRC engine, whose
// init/enable/shift controls are driven from here.
// Optional build macro: CBS_STATS_EN enables the block/descriptor counters;
// without it stat_blk_cnt and stat_tb_cnt are tied to zero.
module cb_seg_ctrl_param #(
    parameter int CNT_W   = 16,
    parameter int NBLK_W  = 4,
    parameter int CRC_LEN = 24,
    parameter int DESC_W  = 3*CNT_W + 2*NBLK_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              desc_empty,
    input  logic [DESC_W-1:0] desc_q,
    output logic              desc_rd,
    input  logic              data_empty,
    output logic              data_rd,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [1:0]        out_sel,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_kplus,
    output logic              crc_init,
    output logic              crc_en,
    output logic              crc_shift,
    output logic              desc_err,
    output logic [15:0]       stat_blk_cnt,
    output logic [15:0]       stat_tb_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC_LD,
        S_BLK_INIT,
        S_FILL,
        S_DATA,
        S_CRC,
        S_BLK_END
    } state_t;

    localparam logic [CNT_W-1:0] L_VAL = CNT_W'(CRC_LEN);

    state_t r_state, r_state_next;

    // latched descriptor fields and per-block counters
    logic [NBLK_W-1:0] r_cplus_left, r_cminus_left;
    logic [CNT_W-1:0]  r_kplus, r_kminus, r_filler, r_l;
    logic [CNT_W-1:0]  r_fill_cnt, r_data_cnt, r_crc_cnt;
    logic              r_first, r_kplus_sel, r_sop_pend;

    // descriptor field decode, only meaningful while in DESC_LD
    logic [CNT_W-1:0]  w_filler, w_kminus, w_kplus, w_l, w_kfirst;
    logic [NBLK_W-1:0] w_cminus, w_cplus;
    logic [NBLK_W:0]   w_c;
    logic              w_bad;

    assign w_filler = desc_q[CNT_W-1:0];
    assign w_kminus = desc_q[2*CNT_W-1:CNT_W];
    assign w_kplus  = desc_q[3*CNT_W-1:2*CNT_W];
    assign w_cminus = desc_q[3*CNT_W+NBLK_W-1:3*CNT_W];
    assign w_cplus  = desc_q[3*CNT_W+2*NBLK_W-1:3*CNT_W+NBLK_W];
    assign w_c      = {1'b0, w_cplus} + {1'b0, w_cminus};
    assign w_l      = (w_c > (NBLK_W+1)'(1)) ? L_VAL : '0;
    assign w_kfirst = (w_cminus != '0) ? w_kminus : w_kplus;

    // a block must hold at least one data bit after filler and CRC
    assign w_bad = (w_c == '0)
                 || ((w_cplus  != '0) && (w_kplus  <= w_l))
                 || ((w_cminus != '0) && (w_kminus <= w_l))
                 || (({1'b0, w_filler} + {1'b0, w_l}) >= {1'b0, w_kfirst});

    // block sizing used in BLK_INIT: K- blocks go first
    logic              w_use_minus;
    logic [CNT_W-1:0]  w_k, w_fill_ld;
    logic              w_more_blk;
    logic              w_xfer;

    assign w_use_minus = (r_cminus_left != '0);
    assign w_k         = w_use_minus ? r_kminus : r_kplus;
    assign w_fill_ld   = r_first ? r_filler : '0;
    assign w_more_blk  = (r_cplus_left != '0) || (r_cminus_left != '0);
    assign out_kplus   = r_kplus_sel;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= r_state_next;
    end

    // next-state and output decode; every transfer-dependent output is
    // gated by out_valid & out_ready so stalls hold everything
    always_comb begin
        r_state_next = r_state;
        desc_rd      = 1'b0;
        data_rd      = 1'b0;
        out_valid    = 1'b0;
        out_sel      = 2'd0;
        out_eop      = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        crc_shift    = 1'b0;
        desc_err     = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!desc_empty && !reset) begin
                    desc_rd      = 1'b1;
                    r_state_next = S_DESC_LD;
                end
            end
            S_DESC_LD: begin
                if (w_bad) begin
                    desc_err     = 1'b1;
                    r_state_next = S_IDLE;
                end else begin
                    r_state_next = S_BLK_INIT;
                end
            end
            S_BLK_INIT: begin
                crc_init     = 1'b1;
                r_state_next = (w_fill_ld != '0) ? S_FILL : S_DATA;
            end
            S_FILL: begin
                out_valid = 1'b1;
                out_sel   = 2'd0;
                w_xfer    = out_ready;
                if (w_xfer && (r_fill_cnt == CNT_W'(1)))
                    r_state_next = S_DATA;
            end
            S_DATA: begin
                out_valid = !data_empty;
                out_sel   = 2'd1;
                w_xfer    = out_valid && out_ready;
                data_rd   = w_xfer;
                crc_en    = w_xfer;
                out_eop   = out_valid && (r_data_cnt == CNT_W'(1)) && (r_l == '0);
                if (w_xfer && (r_data_cnt == CNT_W'(1)))
                    r_state_next = (r_l != '0) ? S_CRC : S_BLK_END;
            end
            S_CRC: begin
                out_valid = 1'b1;
                out_sel   = 2'd2;
                w_xfer    = out_ready;
                crc_shift = w_xfer;
                out_eop   = (r_crc_cnt == CNT_W'(1));
                if (w_xfer && (r_crc_cnt == CNT_W'(1)))
                    r_state_next = S_BLK_END;
            end
            S_BLK_END: begin
                r_state_next = w_more_blk ? S_BLK_INIT : S_IDLE;
            end
            default: r_state_next = S_IDLE;
        endcase
    end

    assign out_sop = out_valid && r_sop_pend;

    // descriptor latch, block setup and bit counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cplus_left  <= '0;
            r_cminus_left <= '0;
            r_kplus       <= '0;
            r_kminus      <= '0;
            r_filler      <= '0;
            r_l           <= '0;
            r_fill_cnt    <= '0;
            r_data_cnt    <= '0;
            r_crc_cnt     <= '0;
            r_first       <= 1'b0;
            r_kplus_sel   <= 1'b0;
            r_sop_pend    <= 1'b0;
        end else begin
            if (w_xfer)
                r_sop_pend <= 1'b0;
            case (r_state)
                S_DESC_LD: begin
                    if (!w_bad) begin
                        r_cplus_left  <= w_cplus;
                        r_cminus_left <= w_cminus;
                        r_kplus       <= w_kplus;
                        r_kminus      <= w_kminus;
                        r_filler      <= w_filler;
                        r_l           <= w_l;
                        r_first       <= 1'b1;
                    end
                end
                S_BLK_INIT: begin
                    r_fill_cnt  <= w_fill_ld;
                    r_data_cnt  <= w_k - r_l - w_fill_ld;
                    r_crc_cnt   <= r_l;
                    r_first     <= 1'b0;
                    r_kplus_sel <= !w_use_minus;
                    r_sop_pend  <= 1'b1;
                    if (w_use_minus) r_cminus_left <= r_cminus_left - NBLK_W'(1);
                    else             r_cplus_left  <= r_cplus_left  - NBLK_W'(1);
                end
                S_FILL: if (w_xfer) r_fill_cnt <= r_fill_cnt - CNT_W'(1);
                S_DATA: if (w_xfer) r_data_cnt <= r_data_cnt - CNT_W'(1);
                S_CRC:  if (w_xfer) r_crc_cnt  <= r_crc_cnt  - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef CBS_STATS_EN
    logic [15:0] r_stat_blk, r_stat_tb;

    // saturating counts of finished blocks and finished descriptors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_blk <= '0;
            r_stat_tb  <= '0;
        end else if (r_state == S_BLK_END) begin
            if (r_stat_blk != 16'hFFFF)
                r_stat_blk <= r_stat_blk + 16'd1;
            if (!w_more_blk && (r_stat_tb != 16'hFFFF))
                r_stat_tb <= r_stat_tb + 16'd1;
        end
    end

    assign stat_blk_cnt = r_stat_blk;
    assign stat_tb_cnt  = r_stat_tb;
`else
    assign stat_blk_cnt = 16'd0;
    assign stat_tb_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_cb_seg_ctrl_param.sv
// Testbench for cb_seg_ctrl_param: directed descriptors, a bit-level model
// of the expected code-block stream, and one per-cycle compare process.
module tb_cb_seg_ctrl_param;

    localparam int DESC_W = 56;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              desc_empty = 1'b1;
    logic [DESC_W-1:0] desc_q = '0;
    logic              data_empty = 1'b0;
    logic              out_ready = 1'b1;
    logic              desc_rd, data_rd, out_valid, out_sop, out_eop, out_kplus;
    logic [1:0]        out_sel;
    logic              crc_init, crc_en, crc_shift, desc_err;
    logic [15:0]       stat_blk_cnt, stat_tb_cnt;

    cb_seg_ctrl_param dut (
        .clk(clk), .reset(reset),
        .desc_empty(desc_empty), .desc_q(desc_q), .desc_rd(desc_rd),
        .data_empty(data_empty), .data_rd(data_rd),
        .out_ready(out_ready), .out_valid(out_valid), .out_sel(out_sel),
        .out_sop(out_sop), .out_eop(out_eop), .out_kplus(out_kplus),
        .crc_init(crc_init), .crc_en(crc_en), .crc_shift(crc_shift),
        .desc_err(desc_err), .stat_blk_cnt(stat_blk_cnt), .stat_tb_cnt(stat_tb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       sop;
        logic       eop;
        logic       kplus;
        logic       last_tb;
    } exp_t;

    exp_t              exp_q[$];
    logic [DESC_W-1:0] dq[$];
    exp_t              h;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit chk_en = 0;
    int n_xfer = 0, n_fill = 0, n_data = 0, n_crc = 0;
    int n_rd = 0, n_crc_en = 0, n_shift = 0, n_init = 0;
    int n_err = 0, exp_err = 0, exp_blk = 0, exp_tb = 0;
    int rd_cyc = 0, lat = -1, gap = -1, last_eop_cyc = -1;
    bit wait_first = 0;
    bit rnd_ready = 0;
    int stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Expand a descriptor into its expected bit stream from first principles.
    task automatic push_desc(input int cp, input int cm, input int kp, input int km, input int f);
        int   c, l, kf, k;
        exp_t e;
        dq.push_back({4'(cp), 4'(cm), 16'(kp), 16'(km), 16'(f)});
        desc_empty = 1'b0;
        c  = cp + cm;
        l  = (c > 1) ? 24 : 0;
        kf = (cm > 0) ? km : kp;
        if (c == 0 || (cp > 0 && kp <= l) || (cm > 0 && km <= l) || (f + l >= kf)) begin
            exp_err++;
        end else begin
            for (int b = 0; b < c; b++) begin
                k = (b < cm) ? km : kp;
                for (int i = 0; i < k; i++) begin
                    e.sel     = (b == 0 && i < f) ? 2'd0 : (i < k - l) ? 2'd1 : 2'd2;
                    e.sop     = (i == 0);
                    e.eop     = (i == k - 1);
                    e.kplus   = (b >= cm);
                    e.last_tb = (b == c - 1);
                    exp_q.push_back(e);
                end
            end
        end
        $display("desc cp=%0d cm=%0d kp=%0d km=%0d f=%0d queued", cp, cm, kp, km, f);
    endtask

    // per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (desc_rd) begin rd_cyc = cyc; wait_first = 1; end
            if (desc_err) n_err++;
            if (crc_init) n_init++;
            if (data_rd)  n_rd++;
            if (crc_en)   n_crc_en++;
            if (crc_shift) n_shift++;
            if (out_valid && wait_first) begin lat = cyc - rd_cyc; wait_first = 0; end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    h = exp_q[0];
                    check("bit_attr", {out_sel, out_sop, out_eop, out_kplus},
                          {h.sel, h.sop, h.eop, h.kplus});
                    if (out_sel == 2'd1) check("valid_while_empty", 64'(data_empty), 64'd0);
                    if (out_sop && last_eop_cyc >= 0) begin
                        gap = cyc - last_eop_cyc;
                        last_eop_cyc = -1;
                    end
                    if (out_ready) begin
                        n_xfer++;
                        if (out_sel == 2'd0) n_fill++;
                        if (out_sel == 2'd1) n_data++;
                        if (out_sel == 2'd2) n_crc++;
                        if (h.eop) begin
                            last_eop_cyc = cyc;
                            exp_blk++;
                            if (h.last_tb) exp_tb++;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_markers", {out_sop, out_eop}, 64'd0);
            end
            check("pop_strobes", {data_rd, crc_en, crc_shift},
                  (out_valid && out_ready) ?
                  {out_sel == 2'd1, out_sel == 2'd1, out_sel == 2'd2} : 3'b000);
        end
    end

    // one clock cycle: service the descriptor FIFO and update ready/empty
    task automatic step();
        bit pop_req;
        @(negedge clk);
        pop_req = desc_rd && !reset && (dq.size() != 0);
        @(posedge clk);
        #1;
        if (pop_req) begin
            desc_q     = dq.pop_front();
            desc_empty = (dq.size() == 0);
        end
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_left > 0) begin
            data_empty = 1'b1;
            stall_left--;
        end else begin
            data_empty = 1'b0;
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || dq.size() != 0 || exp_err != n_err) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("run_timeout", 64'(n), 64'(budget - 1));
        repeat (4) step();
    endtask

    task automatic wait_data(input int nbits);
        int n = 0;
        while (n_data < nbits && n < 200) begin step(); n++; end
        if (n >= 200) check("wait_data_timeout", 64'(n_data), 64'(nbits));
    endtask

    task automatic clear_cnt();
        n_xfer = 0; n_fill = 0; n_data = 0; n_crc = 0;
        n_rd = 0; n_crc_en = 0; n_shift = 0; n_init = 0;
        lat = -1; gap = -1; last_eop_cyc = -1;
    endtask

    task automatic check_stats();
`ifdef CBS_STATS_EN
        check("stat_blk_cnt", 64'(stat_blk_cnt), 64'(exp_blk));
        check("stat_tb_cnt",  64'(stat_tb_cnt),  64'(exp_tb));
`else
        check("stat_blk_cnt", 64'(stat_blk_cnt), 64'd0);
        check("stat_tb_cnt",  64'(stat_tb_cnt),  64'd0);
`endif
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({desc_rd, data_rd, out_valid, out_sel, out_sop, out_eop, out_kplus,
                    crc_init, crc_en, crc_shift, desc_err, stat_blk_cnt, stat_tb_cnt});
    endfunction

    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;
        chk_en = 1;
        step();

        // T1: single K+=40 block, no CRC
        clear_cnt();
        push_desc(1, 0, 40, 0, 0);
        run_idle(300);
        check("T1_xfers", 64'(n_xfer), 64'd40);
        check("T1_data_bits", 64'(n_data), 64'd40);
        check("T1_crc_bits", 64'(n_crc), 64'd0);
        check("T1_data_rd", 64'(n_rd), 64'd40);
        check("T1_latency", 64'(lat), 64'd3);
        check("T1_crc_init", 64'(n_init), 64'd1);
        check_stats();
        $display("T1 xfers=%0d data=%0d lat=%0d", n_xfer, n_data, lat);

        // T2: one K- block with filler then one K+ block, 24 CRC bits each
        clear_cnt();
        push_desc(1, 1, 40, 32, 4);
        run_idle(300);
        check("T2_xfers", 64'(n_xfer), 64'd72);
        check("T2_filler", 64'(n_fill), 64'd4);
        check("T2_data_bits", 64'(n_data), 64'd20);
        check("T2_crc_bits", 64'(n_crc), 64'd48);
        check("T2_crc_shift", 64'(n_shift), 64'd48);
        check("T2_crc_en", 64'(n_crc_en), 64'd20);
        check("T2_block_gap", 64'(gap), 64'd3);
        check("T2_crc_init", 64'(n_init), 64'd2);
        check_stats();
        $display("T2 xfers=%0d fill=%0d data=%0d crc=%0d gap=%0d", n_xfer, n_fill, n_data, n_crc, gap);

        // T3: T2 under random backpressure
        clear_cnt();
        rnd_ready = 1;
        push_desc(1, 1, 40, 32, 4);
        run_idle(1000);
        rnd_ready = 0;
        check("T3_xfers", 64'(n_xfer), 64'd72);
        check("T3_data_rd", 64'(n_rd), 64'd20);
        check("T3_crc_shift", 64'(n_shift), 64'd48);
        $display("T3 xfers=%0d data_rd=%0d", n_xfer, n_rd);

        // T4: data FIFO empty for 5 cycles mid-block
        clear_cnt();
        push_desc(1, 0, 40, 0, 0);
        wait_data(10);
        stall_left = 5;
        run_idle(300);
        check("T4_data_bits", 64'(n_data), 64'd40);
        check("T4_crc_en", 64'(n_crc_en), 64'd40);
        $display("T4 data=%0d crc_en=%0d", n_data, n_crc_en);

        // T5: two bad descriptors then a good one
        clear_cnt();
        e0 = n_err;
        push_desc(0, 0, 40, 32, 0);
        push_desc(2, 0, 24, 0, 0);
        push_desc(1, 0, 40, 0, 0);
        run_idle(300);
        check("T5_desc_err", 64'(n_err - e0), 64'd2);
        check("T5_xfers", 64'(n_xfer), 64'd40);
        check_stats();
        $display("T5 errs=%0d xfers=%0d", n_err - e0, n_xfer);

        // T6: asynchronous reset in the middle of a data phase
        clear_cnt();
        push_desc(1, 0, 40, 0, 0);
        wait_data(10);
        chk_en = 0;
        #1 reset = 1'b1;
        #1 check("T6_reset_outputs", all_outs(), 64'd0);
        exp_q.delete();
        dq.delete();
        desc_empty = 1'b1;
        exp_blk = 0; exp_tb = 0; wait_first = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        step();
        clear_cnt();
        push_desc(1, 0, 40, 0, 0);
        run_idle(300);
        check("T6_data_bits", 64'(n_data), 64'd40);
        check("T6_latency", 64'(lat), 64'd3);
        check_stats();
        $display("T6 data=%0d lat=%0d", n_data, lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
